fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch and program-counter sequencer for the CPU core. It owns the program counter, runs the fetch/execute handshake with instruction memory and the datapath, and applies jumps, halts and wrap-around. It replaces the free-running counter and sits between the instruction memory port and the CPU datapath.

## Interface

Parameters:
- COUNTER_WIDTH, 8, program counter / memory address width
- WIDTH, 8, instruction width
- RESET_VECTOR, 0, program counter value after reset
- FETCH_TIMEOUT, 15, max cycles waiting for mem_ack (used only with FETCH_SEQ_TIMEOUT_EN)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; allows fetching of new instructions
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  COUNTER_WIDTH  fetch address, equals count
- mem_ack  in  1  memory has valid mem_data this cycle
- mem_data  in  WIDTH  instruction word from memory
- instruction  out  WIDTH  latched current instruction
- instr_valid  out  1  one-cycle pulse: new instruction latched
- exec_done  in  1  datapath finished current instruction
- jump  in  1  sampled with exec_done: take jump_target
- jump_target  in  COUNTER_WIDTH  next program counter on jump
- halt_req  in  1  sampled with exec_done: stop after this instruction
- count  out  COUNTER_WIDTH  program counter
- halted  out  1  sequencer in HALT
- fault  out  1  fetch timeout occurred (sticky)

## Operation

- States: IDLE, FETCH, EXEC, HALT. Reset -> IDLE.
- IDLE: if run=1, next edge -> FETCH, mem_req<=1.
- FETCH: mem_req=1, mem_addr=count held stable. On edge with mem_ack=1: instruction<=mem_data, instr_valid<=1, mem_req<=0, -> EXEC. mem_ack while mem_req=0 ignored.
- EXEC: wait for exec_done. On edge with exec_done=1: count<=jump ? jump_target : count+1 (modulo 2^COUNTER_WIDTH, all-ones wraps to 0). Then halt_req=1 -> HALT; else run=1 -> FETCH (mem_req<=1); else IDLE.
- HALT: halted=1, mem_req=0; sticky until reset. run has no effect.
- jump and halt_req are ignored outside an exec_done edge. jump with halt_req: count takes jump_target, then HALT.
- run dropping during FETCH/EXEC does not abort; checked only at exec_done.
- Reset values: count=RESET_VECTOR, instruction=0, instr_valid=0, mem_req=0, halted=0, fault=0.
- Reset asserted mid-fetch: mem_req drops immediately (asynchronous), pending ack discarded.

## Timing

- All outputs registered; mem_addr is count directly.
- Zero-wait memory (mem_ack tied high): FETCH 1 cycle, EXEC >=1 cycle; peak throughput 1 instruction / 2 cycles.
- instr_valid high exactly the first cycle in EXEC; exec_done in that same cycle is legal (single-cycle instruction).
- count changes on the exec_done edge; the following FETCH uses the new value.
- Wait states: each cycle mem_ack=0 in FETCH adds one cycle; no upper bound unless timeout enabled.

## Configuration

- FETCH_SEQ_TIMEOUT_EN defined: a wait counter in FETCH counts cycles with mem_ack=0; when it reaches FETCH_TIMEOUT, next edge sets fault<=1, mem_req<=0, -> HALT. Counter clears on entering FETCH.
- Undefined: no counter, FETCH waits indefinitely, fault tied to 0.

## Test plan

- Reset release, run=1, mem_ack tied high, exec_done tied high, memory returns 8'h10+addr -> count 0,1,2,3 each 2 cycles; instruction 8'h10,8'h11,8'h12; instr_valid one cycle each.
- mem_ack delayed 3 cycles at addr 5 -> mem_req held high 4 cycles with mem_addr=5 stable; instruction latched only on ack edge.
- exec_done with jump=1, jump_target=8'h40 at count 7 -> next mem_addr=8'h40; count=8'hFF, no jump -> wraps to 0.
- exec_done with halt_req=1 and jump=1, target 8'h20 -> count=8'h20, halted=1, mem_req stays 0 while run=1; only reset restores IDLE, count=RESET_VECTOR.
- reset low mid-FETCH (mem_req=1) -> mem_req=0 without a clock edge; all outputs at reset values.
- FETCH_SEQ_TIMEOUT_EN defined, FETCH_TIMEOUT=15, mem_ack never high -> fault=1 and halted=1 after 15 wait cycles; undefined -> mem_req stays high indefinitely, fault=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / program-counter sequencer between instruction memory and the datapath.
// Optional fetch watchdog: define FETCH_SEQ_TIMEOUT_EN to halt with a sticky fault on a stalled fetch.
module fetch_sequencer #(
   parameter int                       COUNTER_WIDTH = 8,
   parameter int                       WIDTH         = 8,
   parameter logic [COUNTER_WIDTH-1:0] RESET_VECTOR  = '0,
   parameter int                       FETCH_TIMEOUT = 15
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     run,
   output logic                     mem_req,
   output logic [COUNTER_WIDTH-1:0] mem_addr,
   input  logic                     mem_ack,
   input  logic [WIDTH-1:0]         mem_data,
   output logic [WIDTH-1:0]         instruction,
   output logic                     instr_valid,
   input  logic                     exec_done,
   input  logic                     jump,
   input  logic [COUNTER_WIDTH-1:0] jump_target,
   input  logic                     halt_req,
   output logic [COUNTER_WIDTH-1:0] count,
   output logic                     halted,
   output logic                     fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   if (FETCH_TIMEOUT < 1) begin : g_bad_timeout
      $error("FETCH_TIMEOUT must be at least 1");
   end

   state_t                   state_r, state_s;
   logic [COUNTER_WIDTH-1:0] count_r, count_s;
   logic [WIDTH-1:0]         instruction_r, instruction_s;
   logic                     instr_valid_r, instr_valid_s;
   logic                     mem_req_r, mem_req_s;
   logic                     halted_r, halted_s;
   logic                     fault_r, fault_s;

`ifdef FETCH_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(FETCH_TIMEOUT + 1);
   logic [TW-1:0] wait_r, wait_s;
`endif

   // Next-state and next-output decode.
   always_comb begin
      state_s       = state_r;
      count_s       = count_r;
      instruction_s = instruction_r;
      instr_valid_s = 1'b0;
      mem_req_s     = mem_req_r;
      halted_s      = halted_r;
      fault_s       = fault_r;
`ifdef FETCH_SEQ_TIMEOUT_EN
      wait_s        = wait_r;
`endif
      case (state_r)
         IDLE: begin
            if (run) begin
               state_s   = FETCH;
               mem_req_s = 1'b1;
`ifdef FETCH_SEQ_TIMEOUT_EN
               wait_s    = '0;
`endif
            end else begin
               mem_req_s = 1'b0;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               instruction_s = mem_data;
               instr_valid_s = 1'b1;
               mem_req_s     = 1'b0;
               state_s       = EXEC;
            end else begin
`ifdef FETCH_SEQ_TIMEOUT_EN
               // The edge that completes the FETCH_TIMEOUT-th wait cycle trips the fault.
               if (wait_r == TW'(FETCH_TIMEOUT - 1)) begin
                  fault_s   = 1'b1;
                  halted_s  = 1'b1;
                  mem_req_s = 1'b0;
                  state_s   = HALT;
               end else begin
                  wait_s    = wait_r + TW'(1);
               end
`else
               mem_req_s = 1'b1;
`endif
            end
         end
         EXEC: begin
            if (exec_done) begin
               count_s = jump ? jump_target : count_r + COUNTER_WIDTH'(1);
               if (halt_req) begin
                  state_s   = HALT;
                  halted_s  = 1'b1;
                  mem_req_s = 1'b0;
               end else if (run) begin
                  state_s   = FETCH;
                  mem_req_s = 1'b1;
`ifdef FETCH_SEQ_TIMEOUT_EN
                  wait_s    = '0;
`endif
               end else begin
                  state_s   = IDLE;
                  mem_req_s = 1'b0;
               end
            end else begin
               mem_req_s = 1'b0;
            end
         end
         HALT: begin
            mem_req_s = 1'b0;
            halted_s  = 1'b1;
         end
         default: begin
            state_s   = IDLE;
            mem_req_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops mem_req without waiting for a clock.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r       <= IDLE;
         count_r       <= RESET_VECTOR;
         instruction_r <= '0;
         instr_valid_r <= 1'b0;
         mem_req_r     <= 1'b0;
         halted_r      <= 1'b0;
         fault_r       <= 1'b0;
`ifdef FETCH_SEQ_TIMEOUT_EN
         wait_r        <= '0;
`endif
      end else begin
         state_r       <= state_s;
         count_r       <= count_s;
         instruction_r <= instruction_s;
         instr_valid_r <= instr_valid_s;
         mem_req_r     <= mem_req_s;
         halted_r      <= halted_s;
         fault_r       <= fault_s;
`ifdef FETCH_SEQ_TIMEOUT_EN
         wait_r        <= wait_s;
`endif
      end
   end

   assign mem_req     = mem_req_r;
   assign mem_addr    = count_r;
   assign count       = count_r;
   assign instruction = instruction_r;
   assign instr_valid = instr_valid_r;
   assign halted      = halted_r;
   assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle table for the main flow, hand sequences for reset and stall.
// Checks the watchdog when FETCH_SEQ_TIMEOUT_EN is defined, otherwise an unbounded stall.
module tb_fetch_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0, mem_ack = 1'b0, exec_done = 1'b0, jump = 1'b0, halt_req = 1'b0;
   logic [7:0] mem_data = 8'h00, jump_target = 8'h00;
   logic       mem_req, instr_valid, halted, fault;
   logic [7:0] mem_addr, instruction, count;

   int checks = 0;
   int errors = 0;

   fetch_sequencer #(.COUNTER_WIDTH(8), .WIDTH(8), .RESET_VECTOR(8'h00), .FETCH_TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .run(run), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_data(mem_data), .instruction(instruction), .instr_valid(instr_valid),
      .exec_done(exec_done), .jump(jump), .jump_target(jump_target), .halt_req(halt_req),
      .count(count), .halted(halted), .fault(fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       run, ack;
      logic [7:0] data;
      logic       done, jmp;
      logic [7:0] tgt;
      logic       hlt;
      logic [7:0] e_count;
      logic       e_req, e_valid;
      logic [7:0] e_instr;
      logic       e_halted;
   } vec_t;

   vec_t vecs[33];

   function automatic vec_t mk(input logic r, input logic a, input logic [7:0] d, input logic dn,
                               input logic j, input logic [7:0] t, input logic h,
                               input logic [7:0] ec, input logic er, input logic ev,
                               input logic [7:0] ei, input logic eh);
      vec_t v;
      v.run = r; v.ack = a; v.data = d; v.done = dn; v.jmp = j; v.tgt = t; v.hlt = h;
      v.e_count = ec; v.e_req = er; v.e_valid = ev; v.e_instr = ei; v.e_halted = eh;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [7:0] ec, input logic er, input logic ev,
                            input logic [7:0] ei, input logic eh, input logic ef);
      check({tag, ".count"}, 32'(count), 32'(ec));
      check({tag, ".mem_addr"}, 32'(mem_addr), 32'(ec));
      check({tag, ".mem_req"}, 32'(mem_req), 32'(er));
      check({tag, ".instr_valid"}, 32'(instr_valid), 32'(ev));
      check({tag, ".instruction"}, 32'(instruction), 32'(ei));
      check({tag, ".halted"}, 32'(halted), 32'(eh));
      check({tag, ".fault"}, 32'(fault), 32'(ef));
   endtask

   initial begin
      //             run  ack   data  done jmp  tgt   hlt  count req  vld  instr halted
      vecs[0]  = mk(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      vecs[1]  = mk(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h10, 1'b0);
      vecs[2]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 8'h10, 1'b0);
      vecs[3]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0);
      vecs[4]  = mk(1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 8'h11, 1'b0);
      vecs[5]  = mk(1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b1, 8'h12, 1'b0);
      vecs[6]  = mk(1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0, 8'h12, 1'b0);
      vecs[7]  = mk(1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b0, 1'b1, 8'h13, 1'b0);
      vecs[8]  = mk(1'b1, 1'b1, 8'h14, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 1'b0, 8'h13, 1'b0);
      vecs[9]  = mk(1'b1, 1'b1, 8'h14, 1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0, 1'b1, 8'h14, 1'b0);
      vecs[10] = mk(1'b1, 1'b1, 8'h15, 1'b1, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 8'h14, 1'b0);
      // three wait states at address 5
      vecs[11] = mk(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 8'h14, 1'b0);
      vecs[12] = mk(1'b1, 1'b0, 8'hAB, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 8'h14, 1'b0);
      vecs[13] = mk(1'b1, 1'b0, 8'hAC, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 1'b0, 8'h14, 1'b0);
      vecs[14] = mk(1'b1, 1'b1, 8'h15, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 1'b1, 8'h15, 1'b0);
      // jump/halt without exec_done are ignored
      vecs[15] = mk(1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 8'h77, 1'b1, 8'h05, 1'b0, 1'b0, 8'h15, 1'b0);
      vecs[16] = mk(1'b1, 1'b1, 8'h16, 1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 1'b1, 1'b0, 8'h15, 1'b0);
      vecs[17] = mk(1'b1, 1'b1, 8'h16, 1'b1, 1'b0, 8'h00, 1'b0, 8'h06, 1'b0, 1'b1, 8'h16, 1'b0);
      vecs[18] = mk(1'b1, 1'b1, 8'h17, 1'b1, 1'b0, 8'h00, 1'b0, 8'h07, 1'b1, 1'b0, 8'h16, 1'b0);
      vecs[19] = mk(1'b1, 1'b1, 8'h17, 1'b1, 1'b0, 8'h00, 1'b0, 8'h07, 1'b0, 1'b1, 8'h17, 1'b0);
      vecs[20] = mk(1'b1, 1'b1, 8'h50, 1'b1, 1'b1, 8'h40, 1'b0, 8'h40, 1'b1, 1'b0, 8'h17, 1'b0);
      vecs[21] = mk(1'b1, 1'b1, 8'h50, 1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 1'b1, 8'h50, 1'b0);
      // run low at exec_done -> IDLE; ack in IDLE ignored
      vecs[22] = mk(1'b0, 1'b1, 8'h98, 1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 1'b0, 8'h50, 1'b0);
      vecs[23] = mk(1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 1'b0, 8'h50, 1'b0);
      vecs[24] = mk(1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0, 8'h50, 1'b0);
      vecs[25] = mk(1'b0, 1'b1, 8'h51, 1'b0, 1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 1'b1, 8'h51, 1'b0);
      vecs[26] = mk(1'b1, 1'b1, 8'h60, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h51, 1'b0);
      vecs[27] = mk(1'b1, 1'b1, 8'h60, 1'b1, 1'b0, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h60, 1'b0);
      // wrap from all-ones
      vecs[28] = mk(1'b1, 1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h60, 1'b0);
      vecs[29] = mk(1'b1, 1'b1, 8'h61, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h61, 1'b0);
      // jump together with halt, then HALT is sticky
      vecs[30] = mk(1'b1, 1'b1, 8'h62, 1'b1, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0, 1'b0, 8'h61, 1'b1);
      vecs[31] = mk(1'b1, 1'b1, 8'h63, 1'b1, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 1'b0, 8'h61, 1'b1);
      vecs[32] = mk(1'b1, 1'b1, 8'h64, 1'b1, 1'b1, 8'h33, 1'b1, 8'h20, 1'b0, 1'b0, 8'h61, 1'b1);

      #2;
      check_all("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 33; i++) begin
         run = vecs[i].run; mem_ack = vecs[i].ack; mem_data = vecs[i].data;
         exec_done = vecs[i].done; jump = vecs[i].jmp; jump_target = vecs[i].tgt;
         halt_req = vecs[i].hlt;
         @(posedge clock);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_req, vecs[i].e_valid,
                   vecs[i].e_instr, vecs[i].e_halted, 1'b0);
         @(negedge clock);
      end

      // Only reset leaves HALT.
      reset = 1'b0;
      #1;
      check_all("halt_reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      run = 1'b1; mem_ack = 1'b0; exec_done = 1'b0; jump = 1'b0; halt_req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_all("fetch_pre_rst", 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      // Asynchronous reset mid-fetch, between clock edges.
      #2;
      mem_ack = 1'b1; mem_data = 8'hEE;
      reset = 1'b0;
      #1;
      check_all("async_rst", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      check_all("rst_held", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Stalled fetch: memory never acknowledges.
      @(negedge clock);
      mem_ack = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_all("stall_enter", 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_SEQ_TIMEOUT_EN
      for (int k = 1; k <= 14; k++) begin
         @(posedge clock);
         #1;
      end
      check_all("stall_14", 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      check_all("timeout", 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      mem_ack = 1'b1;
      @(posedge clock);
      #1;
      check_all("timeout_sticky", 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`else
      for (int k = 1; k <= 40; k++) begin
         @(posedge clock);
         #1;
      end
      check_all("stall_40", 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      mem_ack = 1'b1; mem_data = 8'h5A;
      @(posedge clock);
      #1;
      check_all("stall_ack", 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
